// File: rtl/temp_scan_sequencer_if.sv
// ADC macro control/status bundle shared by the scan sequencer and the ADC.
interface temp_scan_sequencer_if #(
  parameter int ADC_W = 12
);
  logic [7:0]       adc_ctrl;    // [7]=ADC_EN [6]=CLK_EN [5]=ST_CONV [2:0]=mux
  logic             adc_eoc;     // 1-cycle end-of-conversion pulse
  logic [ADC_W-1:0] adc_result;  // valid while adc_eoc=1

  modport master (output adc_ctrl, input adc_eoc, input adc_result);
  modport slave  (input adc_ctrl, output adc_eoc, output adc_result);
endinterface

// File: rtl/temp_scan_sequencer.sv
// Multi-channel temperature scanner: walks the enabled ADC channels, averages
// 2^AVG_LOG2 conversions each, scales to signed degC and flags over-temperature.
module temp_scan_sequencer #(
  parameter int NUM_CH   = 4,
  parameter int ADC_W    = 12,
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = 1023,
  parameter int OFFSET   = 512,
  parameter int GAIN     = 200
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       continuous,
  input  logic [NUM_CH-1:0]          ch_enable,
  input  logic signed [15:0]         alarm_thresh,
  temp_scan_sequencer_if.master      adc,
  output logic [16*NUM_CH-1:0]       temp_out,
  output logic [NUM_CH-1:0]          ch_valid,
  output logic [NUM_CH-1:0]          alarm,
  output logic                       busy,
  output logic                       done,
  output logic                       timeout_err,
  output logic [2:0]                 err_ch
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_CONFIG     = 3'd1;
  localparam logic [2:0] S_START_CONV = 3'd2;
  localparam logic [2:0] S_WAIT_EOC   = 3'd3;
  localparam logic [2:0] S_CONVERT    = 3'd4;
  localparam logic [2:0] S_NEXT_CH    = 3'd5;
  localparam logic [2:0] S_DONE       = 3'd6;

  localparam int ACC_W = ADC_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int MUL_W = ADC_W + 34;

  localparam logic [CNT_W-1:0]        NUM_SAMPLES = CNT_W'(1 << AVG_LOG2);
  localparam logic [TO_W-1:0]         TO_LAST     = TO_W'(TIMEOUT - 1);
  localparam logic signed [MUL_W-1:0] OFFSET_S    = MUL_W'(OFFSET);
  localparam logic signed [MUL_W-1:0] GAIN_S      = MUL_W'(GAIN);
  localparam logic signed [MUL_W-1:0] SAT_MAX     = MUL_W'(32767);
  localparam logic signed [MUL_W-1:0] SAT_MIN     = MUL_W'(-32768);

  logic [2:0]        state;
  logic [2:0]        ch;
  logic [NUM_CH-1:0] mask;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
  logic [TO_W-1:0]   tcnt;

  // Lowest set bit of m at or above index from; returns {found, index}.
  function automatic logic [3:0] find_from(input logic [NUM_CH-1:0] m, input int from);
    logic [3:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i] && i >= from) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  logic [3:0]              first_hit;
  logic [3:0]              next_hit;
  logic [ADC_W-1:0]        avg;
  logic signed [MUL_W-1:0] diff;
  logic signed [MUL_W-1:0] prod;
  logic signed [MUL_W-1:0] shifted;
  logic signed [15:0]      t_sat;

  // Channel search and average-to-degC conversion with 16-bit saturation.
  always_comb begin
    // NOTE: every always_comb output gets a value before any branch so no latch is inferred.
    t_sat     = '0;
    first_hit = find_from(ch_enable, 0);
    next_hit  = find_from(mask, int'(ch) + 1);
    avg       = ADC_W'(acc >> AVG_LOG2);
    diff      = $signed({{(MUL_W - ADC_W){1'b0}}, avg}) - OFFSET_S;
    prod      = diff * GAIN_S;
    shifted   = prod >>> ADC_W;
    if (shifted > SAT_MAX)      t_sat = 16'sh7fff;
    else if (shifted < SAT_MIN) t_sat = 16'sh8000;
    else                        t_sat = shifted[15:0];
  end

  // ADC control byte decoded from the current state and channel.
  always_comb begin
    adc.adc_ctrl = '0;
    case (state)
      S_CONFIG, S_WAIT_EOC, S_CONVERT, S_NEXT_CH: adc.adc_ctrl = {3'b110, 2'b00, ch};
      S_START_CONV:                               adc.adc_ctrl = {3'b111, 2'b00, ch};
      default:                                    adc.adc_ctrl = '0;
    endcase
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // Scan sequencer: state, channel walk, sample accumulation and per-channel results.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the per-channel result registers are reset too, so every output reads 0
    // the moment rst rises, even mid-scan.
    if (rst) begin
      state       <= S_IDLE;
      ch          <= '0;
      mask        <= '0;
      acc         <= '0;
      cnt         <= '0;
      tcnt        <= '0;
      temp_out    <= '0;
      ch_valid    <= '0;
      alarm       <= '0;
      timeout_err <= 1'b0;
      err_ch      <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      case (state)
        S_IDLE: begin
          if (start) begin
            mask        <= ch_enable;
            timeout_err <= 1'b0;
            ch          <= first_hit[2:0];
            state       <= first_hit[3] ? S_CONFIG : S_DONE;
          end
        end
        S_CONFIG: begin
          acc   <= '0;
          cnt   <= '0;
          state <= S_START_CONV;
        end
        S_START_CONV: begin
          tcnt  <= '0;
          state <= S_WAIT_EOC;
        end
        S_WAIT_EOC: begin
          if (adc.adc_eoc) begin
            acc   <= acc + ACC_W'(adc.adc_result);
            cnt   <= cnt + 1'b1;
            state <= (cnt + 1'b1 == NUM_SAMPLES) ? S_CONVERT : S_START_CONV;
          end else if (tcnt == TO_LAST) begin
            timeout_err <= 1'b1;
            err_ch      <= ch;
            for (int i = 0; i < NUM_CH; i++) begin
              if (ch == 3'(i)) ch_valid[i] <= 1'b0;
            end
            state <= S_NEXT_CH;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_CONVERT: begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (ch == 3'(i)) begin
              temp_out[16*i +: 16] <= t_sat;
              ch_valid[i]          <= 1'b1;
              alarm[i]             <= (t_sat > alarm_thresh);
            end
          end
          state <= S_NEXT_CH;
        end
        S_NEXT_CH: begin
          if (next_hit[3]) begin
            ch    <= next_hit[2:0];
            state <= S_CONFIG;
          end else begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (continuous) begin
            mask  <= ch_enable;
            ch    <= first_hit[2:0];
            state <= first_hit[3] ? S_CONFIG : S_DONE;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_temp_scan_sequencer.sv
// Bench for temp_scan_sequencer: a behavioural ADC responder plus a scan-level
// reference model of the expected per-channel results.
module tb_temp_scan_sequencer;

  localparam int NUM_CH   = 4;
  localparam int ADC_W    = 12;
  localparam int AVG_LOG2 = 2;
  localparam int TIMEOUT  = 20;
  localparam int OFFSET   = 512;
  localparam int GAIN     = 200;
  localparam int NSAMP    = 1 << AVG_LOG2;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               continuous;
  logic [3:0]         ch_enable;
  logic signed [15:0] alarm_thresh;
  logic [63:0]        temp_out;
  logic [3:0]         ch_valid;
  logic [3:0]         alarm;
  logic               busy;
  logic               done;
  logic               timeout_err;
  logic [2:0]         err_ch;

  temp_scan_sequencer_if #(.ADC_W(ADC_W)) adc_bus ();

  temp_scan_sequencer #(
    .NUM_CH(NUM_CH), .ADC_W(ADC_W), .AVG_LOG2(AVG_LOG2),
    .TIMEOUT(TIMEOUT), .OFFSET(OFFSET), .GAIN(GAIN)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous),
    .ch_enable(ch_enable), .alarm_thresh(alarm_thresh), .adc(adc_bus),
    .temp_out(temp_out), .ch_valid(ch_valid), .alarm(alarm), .busy(busy),
    .done(done), .timeout_err(timeout_err), .err_ch(err_ch)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ADC behaviour: per-channel EOC delay (0 = never answers), scripted or random data.
  int eoc_delay[NUM_CH];
  int val_q[$];
  int delivered[$];
  int mux_log[$];
  int done_cnt = 0;

  initial begin
    int c, d, v;
    adc_bus.adc_eoc    = 1'b0;
    adc_bus.adc_result = '0;
    forever begin
      @(negedge clk);
      adc_bus.adc_eoc = 1'b0;
      if (!rst && adc_bus.adc_ctrl[5]) begin
        c = int'(adc_bus.adc_ctrl[2:0]);
        mux_log.push_back(c);
        d = (c < NUM_CH) ? eoc_delay[c] : 0;
        if (d > 0) begin
          for (int k = 0; k < d; k++) begin
            @(negedge clk);
            if (rst) break;
          end
          if (!rst) begin
            if (val_q.size() > 0) v = val_q.pop_front();
            else                  v = int'($urandom_range(0, 4095));
            delivered.push_back(v);
            adc_bus.adc_result = ADC_W'(v);
            adc_bus.adc_eoc    = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
  end

  // Reference model: expected visible state after a completed scan.
  logic [15:0] m_temp[NUM_CH];
  bit          m_valid[NUM_CH];
  bit          m_alarm[NUM_CH];
  bit          m_terr;
  int          m_err_ch;
  int          exp_mux[$];

  function automatic int floor_div(input int n, input int d);
    int q;
    q = n / d;
    if ((n % d != 0) && (n < 0)) q--;
    return q;
  endfunction

  task automatic reset_model();
    for (int c = 0; c < NUM_CH; c++) begin
      m_temp[c] = '0; m_valid[c] = 0; m_alarm[c] = 0;
    end
    m_terr = 0; m_err_ch = 0;
    exp_mux.delete();
  endtask

  task automatic model_scan(input logic [3:0] mask, input logic signed [15:0] thr);
    int idx, sum, t;
    idx = 0;
    m_terr = 0;
    exp_mux.delete();
    for (int c = 0; c < NUM_CH; c++) begin
      if (mask[c]) begin
        if (eoc_delay[c] == 0 || eoc_delay[c] > TIMEOUT) begin
          exp_mux.push_back(c);
          m_terr = 1; m_err_ch = c; m_valid[c] = 0;
        end else begin
          sum = 0;
          for (int s = 0; s < NSAMP; s++) begin
            exp_mux.push_back(c);
            if (idx < delivered.size()) sum += delivered[idx];
            idx++;
          end
          t = floor_div((sum / NSAMP - OFFSET) * GAIN, 1 << ADC_W);
          if (t > 32767)  t = 32767;
          if (t < -32768) t = -32768;
          m_temp[c]  = 16'(t);
          m_valid[c] = 1;
          m_alarm[c] = (t > int'(thr));
        end
      end
    end
  endtask

  task automatic compare_state(input string tag);
    int n;
    for (int c = 0; c < NUM_CH; c++) begin
      check($sformatf("%s_temp%0d", tag, c), temp_out[16*c +: 16], m_temp[c]);
      check($sformatf("%s_valid%0d", tag, c), ch_valid[c], m_valid[c]);
      check($sformatf("%s_alarm%0d", tag, c), alarm[c], m_alarm[c]);
    end
    check({tag, "_terr"}, timeout_err, m_terr);
    check({tag, "_err_ch"}, err_ch, m_err_ch);
    check({tag, "_nconv"}, mux_log.size(), exp_mux.size());
    n = (mux_log.size() < exp_mux.size()) ? mux_log.size() : exp_mux.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_mux%0d", tag, i), mux_log[i], exp_mux[i]);
  endtask

  task automatic run_scan(input string tag, input logic [3:0] mask,
                          input logic signed [15:0] thr, input bit poke);
    int cyc, d0;
    mux_log.delete();
    delivered.delete();
    d0 = done_cnt;
    alarm_thresh = thr;
    ch_enable    = mask;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check({tag, "_terr_clr"}, timeout_err, 0);
    cyc = 0;
    while (done !== 1'b1 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (poke && cyc == 8) begin start = 1'b1; ch_enable = ~mask; end
      if (poke && cyc == 9) begin start = 1'b0; ch_enable = mask; end
    end
    start = 1'b0;
    check({tag, "_done_seen"}, cyc < 3000, 1);
    @(negedge clk);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_done_pulses"}, done_cnt - d0, 1);
    model_scan(mask, thr);
    compare_state(tag);
  endtask

  initial begin
    int cyc, gap;
    logic [3:0]         m;
    logic signed [15:0] thr;
    rst = 1'b1; start = 1'b0; continuous = 1'b0;
    ch_enable = '0; alarm_thresh = '0;
    for (int c = 0; c < NUM_CH; c++) eoc_delay[c] = 3;
    reset_model();
    repeat (3) @(negedge clk);
    check("rst_temp", temp_out, 0);
    check("rst_ctrl", adc_bus.adc_ctrl, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_done", done, 0);
    check("idle_valid", ch_valid, 0);

    // Basic single-channel scan: 2560 -> 100 degC, four conversions.
    val_q = '{2560, 2560, 2560, 2560};
    run_scan("basic", 4'b0001, 16'sd150, 0);
    check("basic_t100", temp_out[15:0], 16'd100);
    check("basic_4conv", mux_log.size(), 4);

    val_q = '{0, 0, 0, 0};
    run_scan("zero", 4'b0001, 16'sd150, 0);
    check("zero_tneg25", temp_out[15:0], 16'hFFE7);

    val_q = '{4095, 4095, 4095, 4095};
    run_scan("full150", 4'b0001, 16'sd150, 0);
    check("full_t174", temp_out[15:0], 16'd174);
    check("full_alarm", alarm[0], 1);

    val_q = '{4095, 4095, 4095, 4095};
    run_scan("full174", 4'b0001, 16'sd174, 0);
    check("full174_noalarm", alarm[0], 0);

    val_q = '{2500, 2560, 2620, 2560};
    run_scan("avg", 4'b0001, 16'sd0, 0);
    check("avg_t100", temp_out[15:0], 16'd100);

    // Channel skip with a mid-scan start that must be ignored.
    run_scan("skip", 4'b1010, 16'sd50, 1);
    foreach (mux_log[i]) check("skip_mux_13", (mux_log[i] == 1 || mux_log[i] == 3), 1);
    check("skip_valid", ch_valid, 4'b1011);

    // Timeout on channel 2, scan continues to channel 3.
    eoc_delay[2] = 0;
    run_scan("tmo", 4'b1111, 16'sd80, 0);
    check("tmo_err_ch", err_ch, 3'd2);
    check("tmo_terr", timeout_err, 1);
    eoc_delay[2] = 3;

    // EOC on the last allowed wait cycle is accepted.
    eoc_delay[1] = TIMEOUT;
    run_scan("late", 4'b0011, 16'sd80, 0);
    check("late_terr", timeout_err, 0);
    eoc_delay[1] = 3;

    // Randomized scans.
    for (int n = 0; n < 10; n++) begin
      m   = 4'($urandom_range(1, 15));
      thr = 16'(int'($urandom_range(0, 210)) - 30);
      for (int c = 0; c < NUM_CH; c++) eoc_delay[c] = int'($urandom_range(1, 6));
      if (n % 4 == 3) eoc_delay[$urandom_range(0, NUM_CH - 1)] = 0;
      run_scan($sformatf("rnd%0d", n), m, thr, 0);
    end
    for (int c = 0; c < NUM_CH; c++) eoc_delay[c] = 3;

    // Continuous mode: back-to-back scans without returning to idle.
    continuous = 1'b1; ch_enable = 4'b0101; alarm_thresh = '0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 3000) begin @(negedge clk); cyc++; end
    check("cont_done1", cyc < 3000, 1);
    @(negedge clk);
    gap = 0; cyc = 0;
    while (done !== 1'b1 && cyc < 3000) begin
      if (busy !== 1'b1) gap++;
      @(negedge clk); cyc++;
    end
    check("cont_done2", cyc < 3000, 1);
    check("cont_no_gap", gap, 0);

    // Asynchronous reset in the middle of WAIT_EOC.
    cyc = 0;
    while (adc_bus.adc_ctrl[5] !== 1'b1 && cyc < 200) begin @(negedge clk); cyc++; end
    check("cont_stconv_seen", cyc < 200, 1);
    @(negedge clk); @(negedge clk);
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("arst_ctrl", adc_bus.adc_ctrl, 0);
    check("arst_temp", temp_out, 0);
    check("arst_valid", ch_valid, 0);
    check("arst_busy", busy, 0);
    continuous = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    reset_model();
    mux_log.delete();
    compare_state("post_rst");

    // Empty mask: done without any ADC activity.
    ch_enable = 4'b0000;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("empty_done", done, 1);
    check("empty_ctrl", adc_bus.adc_ctrl, 0);
    @(negedge clk);
    check("empty_done_low", done, 0);
    check("empty_busy_low", busy, 0);
    check("empty_nconv", mux_log.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
